// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: round-robin time-sharing of one seven-segment display with minimum dwell per owner
// Ports: clk, reset (sync, active-high); req per source; encoded_in/digit_point_in per source digits;
// grant (one-hot owner or zero), owner_idx; encoded/digit_point registered to the seven_segment driver.
// Optional macro SEG_ARB_INDICATOR_EN: leftmost digit shows owner_idx with its point lit while granted.
module seg_display_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int NUM_SEGMENTS = 8,
  parameter int CLK_PER = 10,
  parameter int DWELL_US = 1000000
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [NUM_REQ-1:0]                          req,
  input  logic [NUM_REQ-1:0][NUM_SEGMENTS*4-1:0]      encoded_in,
  input  logic [NUM_REQ-1:0][NUM_SEGMENTS-1:0]        digit_point_in,
  output logic [NUM_REQ-1:0]                          grant,
  output logic [$clog2(NUM_REQ)-1:0]                  owner_idx,
  output logic [NUM_SEGMENTS*4-1:0]                   encoded,
  output logic [NUM_SEGMENTS-1:0]                     digit_point
);
  localparam int OW = $clog2(NUM_REQ);
  localparam int DWELL_RAW = DWELL_US * 1000 / CLK_PER;
  localparam int DWELL_CYCLES = DWELL_RAW < 2 ? 2 : DWELL_RAW;
  localparam int CW = $clog2(DWELL_CYCLES);
  // the move to OPEN happens on the edge the counter reaches DWELL_CYCLES-1
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL_CYCLES - 2);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] OPEN = 2'd2;
  logic [1:0] state;
  logic [OW-1:0] last, win_idx;
  logic [CW-1:0] cnt;
  logic [NUM_REQ-1:0] avail;
  logic win_any, rel, take;
  logic [NUM_SEGMENTS*4-1:0] disp;
  logic [NUM_SEGMENTS-1:0] dpv;
  // the current owner never competes, so the same search serves IDLE, OPEN and release
  assign avail = req & ~grant;
  // scan backwards so the closest position after last is the one that sticks
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (avail[OW'((int'(last) + k) % NUM_REQ)]) begin
        win_any = 1'b1;
        win_idx = OW'((int'(last) + k) % NUM_REQ);
      end
    end
  end
  assign rel = state != IDLE && !req[owner_idx];
  assign take = win_any && (state != HOLD || rel);
  always_comb begin
`ifdef SEG_ARB_INDICATOR_EN
    disp = {4'(owner_idx), encoded_in[owner_idx][NUM_SEGMENTS*4-5:0]};
    dpv = {1'b0, digit_point_in[owner_idx][NUM_SEGMENTS-2:0]};
`else
    disp = encoded_in[owner_idx];
    dpv = digit_point_in[owner_idx];
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      owner_idx <= '0;
      last <= OW'(NUM_REQ - 1);
      cnt <= '0;
      encoded <= '0;
      digit_point <= '1;
    end else begin
      encoded <= |grant ? disp : '0;
      digit_point <= |grant ? dpv : '1;
      if (take) begin
        state <= HOLD;
        grant <= ONE << win_idx;
        owner_idx <= win_idx;
        last <= win_idx;
        cnt <= '0;
      end else if (rel) begin
        state <= IDLE;
        grant <= '0;
        owner_idx <= '0;
        cnt <= '0;
      end else if (state == HOLD) begin
        cnt <= cnt + 1'b1;
        if (cnt == CNT_LAST) state <= OPEN;
      end
    end
  end
endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb_seg_display_arbiter: directed and randomized checks of seg_display_arbiter against an ownership-age model
module tb_seg_display_arbiter;
  localparam int N = 4;
  localparam int NS = 8;
  localparam int DW = 100;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0][NS*4-1:0] encoded_in = '0;
  logic [N-1:0][NS-1:0] digit_point_in = '1;
  logic [N-1:0] grant;
  logic [1:0] owner_idx;
  logic [NS*4-1:0] encoded;
  logic [NS-1:0] digit_point;
  int tests = 0;
  int fails = 0;
  int mo = -1;
  int ml = N - 1;
  int age = 0;
  logic [31:0] menc = '0;
  logic [7:0] mdp = 8'hFF;
  always #5 clk = ~clk;
  seg_display_arbiter #(.NUM_REQ(N), .NUM_SEGMENTS(NS), .CLK_PER(10), .DWELL_US(1)) dut (
    .clk(clk), .reset(reset), .req(req), .encoded_in(encoded_in), .digit_point_in(digit_point_in),
    .grant(grant), .owner_idx(owner_idx), .encoded(encoded), .digit_point(digit_point)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic int rr_pick();
    for (int k = 1; k <= N; k++) begin
      int c = (ml + k) % N;
      if (req[c] && c != mo) return c;
    end
    return -1;
  endfunction
  task automatic step();
    int w;
    @(posedge clk);
    if (reset) begin
      mo = -1; ml = N - 1; age = 0; menc = '0; mdp = 8'hFF;
    end else begin
      if (mo < 0) begin
        menc = '0; mdp = 8'hFF;
      end else begin
        menc = encoded_in[mo]; mdp = digit_point_in[mo];
`ifdef SEG_ARB_INDICATOR_EN
        menc[31:28] = 4'(mo); mdp[7] = 1'b0;
`endif
      end
      w = rr_pick();
      if (mo >= 0 && !req[mo]) begin
        mo = w; age = 1;
        if (w >= 0) ml = w;
      end else if (w >= 0 && (mo < 0 || age >= DW)) begin
        mo = w; ml = w; age = 1;
      end else if (mo >= 0) age++;
    end
    #1;
    chk("grant", 32'(grant), mo < 0 ? 0 : (1 << mo));
    chk("owner_idx", 32'(owner_idx), mo < 0 ? 0 : mo);
    chk("encoded", encoded, menc);
    chk("digit_point", 32'(digit_point), 32'(mdp));
  endtask
  initial begin
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    req = 4'b0000;
    repeat (20) step();
    chk("idle_grant", 32'(grant), 0);
    chk("idle_dp", 32'(digit_point), 32'hFF);
    req = 4'b0110;
    step();
    chk("rr_first", 32'(grant), 32'b0010);
    for (int i = 0; i < 99; i++) begin
      step();
      chk("dwell_hold", 32'(grant), 32'b0010);
    end
    step();
    chk("dwell_switch", 32'(grant), 32'b0100);
    reset = 1'b1; step(); reset = 1'b0;
    req = 4'b1010;
    step();
    chk("own1", 32'(grant), 32'b0010);
    repeat (30) step();
    req = 4'b1000;
    step();
    chk("release_to3", 32'(grant), 32'b1000);
    req = 4'b1001;
    repeat (99) step();
    chk("restart_hold", 32'(grant), 32'b1000);
    step();
    chk("restart_switch", 32'(grant), 32'b0001);
    reset = 1'b1; step(); reset = 1'b0;
    req = 4'b0001;
    for (int i = 0; i < 500; i++) begin
      encoded_in[0] = {4'h0, 28'($urandom)};
      digit_point_in[0] = 8'($urandom);
      step();
    end
    chk("single_owner", 32'(grant), 32'b0001);
    encoded_in[0] = 32'h0ABCDEF1;
    step();
    chk("lag_encoded", encoded, 32'h0ABCDEF1);
    req = 4'b0100;
    repeat (6) step();
    chk("hold2", 32'(grant), 32'b0100);
    reset = 1'b1;
    step();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_enc", encoded, 0);
    chk("rst_dp", 32'(digit_point), 32'hFF);
    reset = 1'b0;
    req = 4'b1111;
    step();
    chk("rst_rr0", 32'(grant), 32'b0001);
`ifdef SEG_ARB_INDICATOR_EN
    reset = 1'b1; step(); reset = 1'b0;
    req = 4'b0100;
    encoded_in[2] = 32'h12345678;
    step(); step();
    chk("ind_enc", encoded, 32'h22345678);
    chk("ind_dp7", 32'(digit_point[7]), 0);
`endif
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) req = 4'($urandom);
      encoded_in[$urandom_range(N - 1)] = $urandom;
      digit_point_in[$urandom_range(N - 1)] = 8'($urandom);
      reset = $urandom_range(499) == 0;
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
